// File: rtl/serial_link_vc_credit_arbiter_if.sv
// Bundles the per-VC request side, the outgoing packet stream and the
// credit bookkeeping inputs of the multi-VC credit arbiter.
interface serial_link_vc_credit_arbiter_if #(
    parameter int  NumChannels = 2,
    parameter int  NumCredits  = 8,
    parameter type data_t      = logic
);
    localparam int IdxW  = $clog2(NumChannels);
    localparam int CredW = $clog2(NumCredits + 1);

    // Per-VC payload requests
    logic [NumChannels-1:0] req_valid_i;
    data_t                  req_data_i [NumChannels];
    logic [NumChannels-1:0] req_ready_o;

    // Outgoing packet stream
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic                   out_is_data_o;
    logic [IdxW-1:0]        out_vc_o;
    data_t                  out_data_o;
    logic [IdxW-1:0]        out_credit_vc_o;
    logic [CredW-1:0]       out_credits_o;

    // Credit bookkeeping
    logic                   rx_credit_valid_i;
    logic [IdxW-1:0]        rx_credit_vc_i;
    logic [CredW-1:0]       rx_credits_i;
    logic [NumChannels-1:0] rx_consume_i;

    modport slave (
        input  req_valid_i, req_data_i,
        output req_ready_o,
        output out_valid_o, out_is_data_o, out_vc_o, out_data_o,
        output out_credit_vc_o, out_credits_o,
        input  out_ready_i,
        input  rx_credit_valid_i, rx_credit_vc_i, rx_credits_i, rx_consume_i
    );

    modport master (
        output req_valid_i, req_data_i,
        input  req_ready_o,
        input  out_valid_o, out_is_data_o, out_vc_o, out_data_o,
        input  out_credit_vc_o, out_credits_o,
        output out_ready_i,
        output rx_credit_valid_i, rx_credit_vc_i, rx_credits_i, rx_consume_i
    );
endinterface

// File: rtl/serial_link_vc_credit_arbiter.sv
// Multi-VC credit arbiter: round-robins payload requests among VCs that hold
// transmit credits, piggybacks one VC's pending credit return on each packet,
// and forces credit-only packets when returns pile up with no data to send.
module serial_link_vc_credit_arbiter #(
    parameter int  NumChannels     = 2,
    parameter int  NumCredits      = 8,
    parameter int  ForceSendThresh = NumCredits - 4,
    parameter type data_t          = logic,
    localparam int IdxW            = $clog2(NumChannels),
    localparam int CredW           = $clog2(NumCredits + 1)
) (
    input logic                           clk_i,
    input logic                           rst_i,
    serial_link_vc_credit_arbiter_if.slave link
);

    // First set bit of mask at or after ptr, wrapping; MSB flags a hit.
    function automatic logic [IdxW:0] rr_pick(input logic [NumChannels-1:0] mask,
                                              input logic [IdxW-1:0]        ptr);
        logic [IdxW:0] r;
        int            j;
        r = '0;
        // Walk from farthest to nearest so the nearest hit wins.
        for (int i = NumChannels - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NumChannels;
            if (mask[j]) r = {1'b1, IdxW'(j)};
        end
        return r;
    endfunction

    function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] i);
        return IdxW'((int'(i) + 1) % NumChannels);
    endfunction

    logic [CredW-1:0] avail_q [NumChannels];
    logic [CredW-1:0] avail_d [NumChannels];
    logic [CredW-1:0] pend_q  [NumChannels];
    logic [CredW-1:0] pend_d  [NumChannels];
    logic [IdxW-1:0]  data_ptr_q, data_ptr_d;
    logic [IdxW-1:0]  cred_ptr_q, cred_ptr_d;

    logic             valid_q, valid_d;
    logic             is_data_q, is_data_d;
    logic [IdxW-1:0]  vc_q, vc_d;
    data_t            data_q, data_d;
    logic [IdxW-1:0]  credit_vc_q, credit_vc_d;
    logic [CredW-1:0] credits_q, credits_d;

    logic [NumChannels-1:0] pend_nz, elig, grant, clear;
    logic                   any_pend, force_send;
    logic                   load_en, do_data, do_cred;
    logic [IdxW:0]          data_pick, cred_pick;
    logic [IdxW-1:0]        g_idx, k_idx;
    logic                   k_found;

    // Eligibility: the last credit of a VC may only go out carrying a credit return.
    always_comb begin
        pend_nz    = '0;
        elig       = '0;
        any_pend   = 1'b0;
        force_send = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            pend_nz[c] = (pend_q[c] != '0);
            if (pend_q[c] >= CredW'(ForceSendThresh)) force_send = 1'b1;
        end
        any_pend = |pend_nz;
        for (int c = 0; c < NumChannels; c++) begin
            elig[c] = link.req_valid_i[c] && (avail_q[c] != '0) &&
                      ((avail_q[c] != CredW'(1)) || any_pend);
        end
    end

    assign data_pick = rr_pick(elig, data_ptr_q);
    assign cred_pick = rr_pick(pend_nz, cred_ptr_q);
    assign g_idx     = data_pick[IdxW-1:0];
    assign k_idx     = cred_pick[IdxW-1:0];
    assign k_found   = cred_pick[IdxW];

    // A new packet may enter when the output register is empty or draining this cycle.
    assign load_en = !valid_q || link.out_ready_i;
    assign do_data = load_en && data_pick[IdxW];
    assign do_cred = load_en && !data_pick[IdxW] && force_send;

    // Next-state: packet load, pointer advance and concurrent counter updates.
    always_comb begin
        valid_d     = valid_q;
        is_data_d   = is_data_q;
        vc_d        = vc_q;
        data_d      = data_q;
        credit_vc_d = credit_vc_q;
        credits_d   = credits_q;
        data_ptr_d  = data_ptr_q;
        cred_ptr_d  = cred_ptr_q;
        grant       = '0;
        clear       = '0;

        if (do_data || do_cred) begin
            valid_d   = 1'b1;
            is_data_d = do_data;
            vc_d      = do_data ? g_idx : '0;
            data_d    = do_data ? link.req_data_i[g_idx] : '0;
            if (do_data) begin
                grant[g_idx] = 1'b1;
                data_ptr_d   = rr_next(g_idx);
            end
            if (k_found) begin
                credit_vc_d  = k_idx;
                credits_d    = pend_q[k_idx];
                clear[k_idx] = 1'b1;
                cred_ptr_d   = rr_next(k_idx);
            end else begin
                credit_vc_d  = '0;
                credits_d    = '0;
            end
        end else if (load_en) begin
            valid_d     = 1'b0;
            is_data_d   = 1'b0;
            vc_d        = '0;
            data_d      = '0;
            credit_vc_d = '0;
            credits_d   = '0;
        end

        for (int c = 0; c < NumChannels; c++) begin
            avail_d[c] = avail_q[c] - CredW'(grant[c]) +
                         ((link.rx_credit_valid_i && (int'(link.rx_credit_vc_i) == c)) ?
                          link.rx_credits_i : '0);
            pend_d[c]  = (clear[c] ? '0 : pend_q[c]) + CredW'(link.rx_consume_i[c]);
        end
    end

    // State register: counters, pointers and the outgoing packet.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChannels; c++) begin
                avail_q[c] <= CredW'(NumCredits);
                pend_q[c]  <= '0;
            end
            data_ptr_q  <= '0;
            cred_ptr_q  <= '0;
            valid_q     <= 1'b0;
            is_data_q   <= 1'b0;
            vc_q        <= '0;
            data_q      <= '0;
            credit_vc_q <= '0;
            credits_q   <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                avail_q[c] <= avail_d[c];
                pend_q[c]  <= pend_d[c];
            end
            data_ptr_q  <= data_ptr_d;
            cred_ptr_q  <= cred_ptr_d;
            valid_q     <= valid_d;
            is_data_q   <= is_data_d;
            vc_q        <= vc_d;
            data_q      <= data_d;
            credit_vc_q <= credit_vc_d;
            credits_q   <= credits_d;
        end
    end

    assign link.req_ready_o     = rst_i ? '0 : grant;
    assign link.out_valid_o     = valid_q;
    assign link.out_is_data_o   = is_data_q;
    assign link.out_vc_o        = vc_q;
    assign link.out_data_o      = data_q;
    assign link.out_credit_vc_o = credit_vc_q;
    assign link.out_credits_o   = credits_q;

    // Counter bounds and input sanity; violations mean a misbehaving neighbour.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (ForceSendThresh > 0);
            for (int c = 0; c < NumChannels; c++) begin
                assert (avail_q[c] <= CredW'(NumCredits));
                assert (pend_q[c] <= CredW'(NumCredits));
            end
            if (link.rx_credit_valid_i) assert (int'(link.rx_credit_vc_i) < NumChannels);
        end
    end

endmodule

// File: tb/tb_serial_link_vc_credit_arbiter.sv
// Bench for the multi-VC credit arbiter: vector table, directed corner
// sequences and a randomized run against a packet-level reference model.
module tb_serial_link_vc_credit_arbiter;
    localparam int NCH = 2;
    localparam int NCR = 8;
    localparam int THR = NCR - 4;
    typedef logic [7:0] dat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_link_vc_credit_arbiter_if #(.NumChannels(NCH), .NumCredits(NCR), .data_t(dat_t)) link();

    serial_link_vc_credit_arbiter #(
        .NumChannels(NCH), .NumCredits(NCR), .ForceSendThresh(THR), .data_t(dat_t)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .link (link)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // {valid, is_data, vc, data, credit_vc, credits}
    function automatic logic [15:0] pk(logic v, logic isd, logic vc, logic [7:0] d,
                                       logic cvc, logic [3:0] cr);
        return {v, isd, vc, d, cvc, cr};
    endfunction

    function automatic logic [15:0] dut_pkt();
        return pk(link.out_valid_o, link.out_is_data_o, link.out_vc_o, link.out_data_o,
                  link.out_credit_vc_o, link.out_credits_o);
    endfunction

    task automatic idle_inputs();
        link.req_valid_i       = '0;
        link.req_data_i[0]     = 8'hA0;
        link.req_data_i[1]     = 8'hB1;
        link.out_ready_i       = 1'b1;
        link.rx_credit_valid_i = 1'b0;
        link.rx_credit_vc_i    = '0;
        link.rx_credits_i      = '0;
        link.rx_consume_i      = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int          m_avail [NCH];
    int          m_pend  [NCH];
    int          m_dptr, m_cptr;
    logic        m_v, m_isd;
    int          m_vc, m_cvc, m_cr;
    logic [7:0]  m_data;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_avail[c] = NCR;
            m_pend[c]  = 0;
        end
        m_dptr = 0; m_cptr = 0;
        m_v = 0; m_isd = 0; m_vc = 0; m_cvc = 0; m_cr = 0; m_data = '0;
    endtask

    // Applies one clock of the arbitration rules to the model and returns the
    // payload-taken vector expected during that clock.
    task automatic model_cycle(output logic [NCH-1:0] exp_rdy);
        int  g, k, c;
        bit  any_p, frc, room;
        exp_rdy = '0;
        if (rst) begin
            model_reset();
            return;
        end
        any_p = 0; frc = 0;
        for (int i = 0; i < NCH; i++) begin
            if (m_pend[i] > 0)    any_p = 1;
            if (m_pend[i] >= THR) frc = 1;
        end
        g = -1; k = -1;
        for (int i = 0; i < NCH; i++) begin
            c = (m_dptr + i) % NCH;
            if (g < 0 && link.req_valid_i[c] && m_avail[c] > 0 && (m_avail[c] > 1 || any_p))
                g = c;
            c = (m_cptr + i) % NCH;
            if (k < 0 && m_pend[c] > 0) k = c;
        end
        room = !m_v || link.out_ready_i;
        if (room && (g >= 0 || frc)) begin
            m_v    = 1;
            m_isd  = (g >= 0);
            m_vc   = (g >= 0) ? g : 0;
            m_data = (g >= 0) ? link.req_data_i[g] : 8'h00;
            if (g >= 0) begin
                exp_rdy[g] = 1'b1;
                m_avail[g] = m_avail[g] - 1;
                m_dptr     = (g + 1) % NCH;
            end
            if (k >= 0) begin
                m_cvc     = k;
                m_cr      = m_pend[k];
                m_pend[k] = 0;
                m_cptr    = (k + 1) % NCH;
            end else begin
                m_cvc = 0; m_cr = 0;
            end
        end else if (room) begin
            m_v = 0; m_isd = 0; m_vc = 0; m_data = '0; m_cvc = 0; m_cr = 0;
        end
        if (link.rx_credit_valid_i)
            m_avail[link.rx_credit_vc_i] = m_avail[link.rx_credit_vc_i] + int'(link.rx_credits_i);
        for (int i = 0; i < NCH; i++)
            if (link.rx_consume_i[i]) m_pend[i] = m_pend[i] + 1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] rv;
        logic [1:0] cons;
        logic [1:0] exp_rdy;
        logic [15:0] exp_pkt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [NCH-1:0] mrdy;
        int             cnt;

        // Round robin with both VCs requesting, then credit pile-up forcing a credit-only packet.
        for (int i = 0; i < 8; i++) begin
            tbl[i].rv      = 2'b11;
            tbl[i].cons    = 2'b00;
            tbl[i].exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            tbl[i].exp_pkt = (i % 2 == 0) ? pk(1, 1, 0, 8'hA0, 0, 0) : pk(1, 1, 1, 8'hB1, 0, 0);
        end
        for (int i = 8; i < 12; i++) begin
            tbl[i].rv = 2'b00; tbl[i].cons = 2'b10; tbl[i].exp_rdy = 2'b00; tbl[i].exp_pkt = '0;
        end
        tbl[12] = '{rv: 2'b00, cons: 2'b00, exp_rdy: 2'b00, exp_pkt: pk(1, 0, 0, 8'h00, 1, 4)};
        tbl[13] = '{rv: 2'b00, cons: 2'b00, exp_rdy: 2'b00, exp_pkt: '0};

        idle_inputs();
        rst = 1'b1;
        step();
        step();
        chk("reset_pkt", 32'(dut_pkt()), 32'h0);
        chk("reset_ready", 32'(link.req_ready_o), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            link.req_valid_i  = tbl[i].rv;
            link.rx_consume_i = tbl[i].cons;
            @(negedge clk);
            chk($sformatf("tbl_ready[%0d]", i), 32'(link.req_ready_o), 32'(tbl[i].exp_rdy));
            step();
            chk($sformatf("tbl_pkt[%0d]", i), 32'(dut_pkt()), 32'(tbl[i].exp_pkt));
        end
        chk("tbl_avail0", 32'(dut.avail_q[0]), 32'd4);
        chk("tbl_avail1", 32'(dut.avail_q[1]), 32'd4);

        // Last credit of VC0 withheld until a credit return exists.
        do_reset();
        link.req_valid_i = 2'b01;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (link.req_ready_o[0]) cnt++;
            step();
        end
        chk("lastcred_payloads", 32'(cnt), 32'd7);
        chk("lastcred_withheld", 32'(link.out_valid_o), 32'd0);
        link.rx_consume_i = 2'b10;
        @(negedge clk);
        chk("lastcred_ready_before", 32'(link.req_ready_o), 32'h0);
        step();
        link.rx_consume_i = 2'b00;
        @(negedge clk);
        chk("lastcred_ready", 32'(link.req_ready_o), 32'h1);
        step();
        chk("lastcred_pkt", 32'(dut_pkt()), 32'(pk(1, 1, 0, 8'hA0, 1, 1)));

        // Output held under back-pressure while inputs churn; pending returns keep accruing.
        do_reset();
        link.req_valid_i   = 2'b01;
        link.req_data_i[0] = 8'h11;
        link.out_ready_i   = 1'b0;
        step();
        chk("hold_load", 32'(dut_pkt()), 32'(pk(1, 1, 0, 8'h11, 0, 0)));
        for (int i = 0; i < 5; i++) begin
            link.req_data_i[0] = 8'h40 + 8'(i);
            link.req_data_i[1] = 8'($urandom);
            link.req_valid_i   = 2'b11;
            link.rx_consume_i  = 2'b10;
            @(negedge clk);
            chk($sformatf("hold_ready[%0d]", i), 32'(link.req_ready_o), 32'h0);
            step();
            chk($sformatf("hold_pkt[%0d]", i), 32'(dut_pkt()), 32'(pk(1, 1, 0, 8'h11, 0, 0)));
        end
        link.rx_consume_i  = 2'b00;
        link.req_valid_i   = 2'b01;
        link.req_data_i[0] = 8'h22;
        link.out_ready_i   = 1'b1;
        @(negedge clk);
        chk("hold_release_ready", 32'(link.req_ready_o), 32'h1);
        step();
        chk("hold_release_pkt", 32'(dut_pkt()), 32'(pk(1, 1, 0, 8'h22, 1, 5)));

        // Reset while a packet is stalled.
        link.out_ready_i  = 1'b0;
        link.rx_consume_i = 2'b01;
        rst = 1'b1;
        step();
        rst = 1'b0;
        link.rx_consume_i = 2'b00;
        link.req_valid_i  = 2'b00;
        chk("rst_mid_pkt", 32'(dut_pkt()), 32'h0);
        chk("rst_avail0", 32'(dut.avail_q[0]), 32'd8);
        chk("rst_avail1", 32'(dut.avail_q[1]), 32'd8);
        chk("rst_pend0", 32'(dut.pend_q[0]), 32'd0);
        chk("rst_pend1", 32'(dut.pend_q[1]), 32'd0);
        chk("rst_ptrs", 32'({dut.data_ptr_q, dut.cred_ptr_q}), 32'h0);

        // Grant and credit arrival on the same VC in the same cycle.
        do_reset();
        link.req_valid_i = 2'b01;
        repeat (3) step();
        chk("samecyc_avail_before", 32'(dut.avail_q[0]), 32'd5);
        link.rx_credit_valid_i = 1'b1;
        link.rx_credit_vc_i    = 1'b0;
        link.rx_credits_i      = 4'd3;
        @(negedge clk);
        chk("samecyc_ready", 32'(link.req_ready_o), 32'h1);
        step();
        link.rx_credit_valid_i = 1'b0;
        link.req_valid_i       = 2'b00;
        chk("samecyc_avail", 32'(dut.avail_q[0]), 32'd7);

        // Randomized traffic against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int vc, n;
            rst                = (($urandom % 200) == 0);
            link.req_valid_i   = 2'($urandom);
            link.req_data_i[0] = 8'($urandom);
            link.req_data_i[1] = 8'($urandom);
            link.out_ready_i   = (($urandom % 4) != 0);
            vc = int'($urandom % NCH);
            n  = int'($urandom_range(1, 3));
            link.rx_credit_valid_i = (($urandom % 3) == 0) && (m_avail[vc] + n <= NCR);
            link.rx_credit_vc_i    = 1'(vc);
            link.rx_credits_i      = 4'(n);
            for (int c = 0; c < NCH; c++)
                link.rx_consume_i[c] = (($urandom % 3) == 0) && (m_pend[c] < NCR);
            @(negedge clk);
            chk($sformatf("rand_pkt[%0d]", cyc), 32'(dut_pkt()),
                32'(pk(m_v, m_isd, 1'(m_vc), m_data, 1'(m_cvc), 4'(m_cr))));
            model_cycle(mrdy);
            chk($sformatf("rand_ready[%0d]", cyc), 32'(link.req_ready_o), 32'(mrdy));
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_link_vc_credit_arbiter.md
Name: serial_link_vc_credit_arbiter

Overview:
Shares one outgoing serial-link packet stream between NumChannels virtual channels (VCs), each with independent credit-based flow control. It round-robins data requests among VCs that hold credits and piggybacks returned credits for one VC per packet. When credits pile up and no data is pending, it forces credit-only packets. It sits between the per-VC protocol queues and the link layer, and generalises single-channel credit synchronisation to multiple VCs.

Parameters:
NumChannels, 2, number of VCs (>=2).
NumCredits, 8, credits per VC at reset; equals receiver buffer depth per VC.
ForceSendThresh, NumCredits-4, pending-return level that forces a credit-only packet; must be >0.
data_t, logic, payload type.
IdxW, $clog2(NumChannels), VC index width (derived).
CredW, $clog2(NumCredits+1), credit counter width (derived).

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, synchronous, active-high.
req_valid_i  in  NumChannels  per-VC payload valid.
req_data_i  in  NumChannels x data_t  per-VC payload.
req_ready_o  out  NumChannels  one-cycle pulse: payload taken.
out_valid_o  out  1  packet valid.
out_ready_i  in  1  link accepts packet.
out_is_data_o  out  1  1 = payload packet, 0 = credit-only.
out_vc_o  out  IdxW  VC of the payload.
out_data_o  out  data_t  payload; '0 when out_is_data_o=0.
out_credit_vc_o  out  IdxW  VC whose credits are returned.
out_credits_o  out  CredW  number of credits returned.
rx_credit_valid_i  in  1  credits arrived from the far side.
rx_credit_vc_i  in  IdxW  VC of the arrived credits.
rx_credits_i  in  CredW  arrived credit count.
rx_consume_i  in  NumChannels  local receiver freed one buffer slot for VC c.

Behaviour:
- Per-VC state: avail_q[c] (reset NumCredits) and pend_q[c] (reset 0). Round-robin pointers data_ptr_q and cred_ptr_q (reset 0). Output register: valid, is_data, vc, data, credit_vc, credits.
- Reset values: out_valid_o=0, req_ready_o=0, all other outputs 0. rst_i applied mid-packet drops out_valid_o at the next edge and discards the packet. Its payload is not re-requested.
- Eligibility: VC c is eligible when req_valid_i[c] and avail_q[c]>0. If avail_q[c]==1, VC c is eligible only when some pend_q>0, so the last credit always carries a credit return (deadlock avoidance).
- Credit VC choice: first VC with pend_q>0 at or after cred_ptr_q.
- Load condition: output register empty, or out_valid_o & out_ready_i in the same cycle. This allows back-to-back packets.
- Load with a data packet (any eligible VC): grant the first eligible VC at or after data_ptr_q.
  - Pulse req_ready_o[g] and capture req_data_i[g].
  - avail_q[g]-- .
  - Set data_ptr_q = g+1 (wrap at NumChannels).
- Load with a credit-only packet: no eligible VC and some pend_q >= ForceSendThresh. Set is_data=0 and data='0. No avail change.
- On either load:
  - If a credit VC k exists, set credits=pend_q[k], credit_vc=k, and cred_ptr_q=k+1.
  - Otherwise set credits=0 and credit_vc=0.
  - pend_q[k] is cleared. A same-cycle rx_consume_i[k] makes pend_q[k]=1.
- Nothing to load: the output register clears on handshake (out_valid_o=0).
- Stability: while out_valid_o=1 and out_ready_i=0, all out_* are held. No counter is applied to the held packet.
- Latency: a request presented in an idle cycle with credits gives out_valid_o at the next edge (1 cycle).
- Counter updates, all concurrent:
  - avail_q[c] = avail_q[c] - grant[c] + (rx_credit_valid_i & rx_credit_vc_i==c ? rx_credits_i : 0).
  - pend_q[c] = (cleared ? 0 : pend_q[c]) + rx_consume_i[c].
- Assertions: avail_q<=NumCredits, pend_q<=NumCredits, rx_credit_vc_i<NumChannels, ForceSendThresh>0. No clamping in RTL.

Test Plan:
1. Reset, then req_valid_i=2'b11 held and out_ready_i=1 -> grants alternate VC0, VC1, VC0... one per cycle. After 8 packets avail_q={4,4} and no credit-only packets.
2. VC0 only, no rx credits, no consumes, out_ready_i=1 -> exactly 7 payloads. The 8th is withheld (avail=1, pend all 0) until a single rx_consume_i[1] pulse. The next packet then carries VC0 data with credit_vc=1, credits=1.
3. No requests, 4 rx_consume_i[1] pulses -> pend_q[1]=4 reaches threshold. The next cycle gives out_valid_o=1, is_data=0, credit_vc=1, credits=4, data=0.
4. Packet loaded, out_ready_i=0 for 5 cycles while req_data_i changes and rx_consume_i pulses -> out_* unchanged. pend_q still accumulates and is reported in the next packet.
5. Same cycle: VC0 granted, rx_credit_valid_i for VC0 with rx_credits_i=3, avail_q[0]=5 -> avail_q[0]=7.
6. rst_i asserted while out_valid_o=1 and out_ready_i=0 -> next cycle out_valid_o=0, avail_q all 8, pend_q all 0, pointers 0.
